// File: rtl/cover_scan_pkg.sv
// Shared definitions for the coverage scanner: widths, mode codes, grid limits
// and the packing of the circle centre/radius buses.
package cover_scan_pkg;

    localparam int COORD_W     = 4;
    localparam int GRID_MIN    = 1;
    localparam int GRID_MAX    = 8;
    localparam int NUM_CIRCLES = 3;
    localparam int COVERED_SZ  = 3;
    localparam int MODE_SZ     = 2;
    localparam int CENTRAL_W   = 2 * COORD_W * NUM_CIRCLES;
    localparam int RADIUS_W    = COORD_W * NUM_CIRCLES;

    localparam logic [MODE_SZ-1:0] MODE1 = 2'd0;
    localparam logic [MODE_SZ-1:0] MODE2 = 2'd1;
    localparam logic [MODE_SZ-1:0] MODE3 = 2'd2;
    localparam logic [MODE_SZ-1:0] MODE4 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Circle 0 (A) occupies the most significant field of each bus.
    function automatic logic [COORD_W-1:0] centre_x(input logic [CENTRAL_W-1:0] c, input int i);
        return c[CENTRAL_W-1-2*COORD_W*i -: COORD_W];
    endfunction

    function automatic logic [COORD_W-1:0] centre_y(input logic [CENTRAL_W-1:0] c, input int i);
        return c[CENTRAL_W-1-COORD_W-2*COORD_W*i -: COORD_W];
    endfunction

    function automatic logic [COORD_W-1:0] radius_of(input logic [RADIUS_W-1:0] r, input int i);
        return r[RADIUS_W-1-COORD_W*i -: COORD_W];
    endfunction

endpackage

// File: rtl/cover_scan_if.sv
// Start/configuration inputs and per-point result outputs of the coverage scanner.
interface cover_scan_if;
    import cover_scan_pkg::*;

    logic                  en_i;
    logic [CENTRAL_W-1:0]  central_i;
    logic [RADIUS_W-1:0]   radius_i;
    logic [MODE_SZ-1:0]    mode_i;
    logic                  busy_o;
    logic [COVERED_SZ-1:0] covered_o;
    logic                  pt_valid_o;
    logic                  last_o;
    logic [MODE_SZ-1:0]    mode_buf_o;

    modport master (
        output en_i, central_i, radius_i, mode_i,
        input  busy_o, covered_o, pt_valid_o, last_o, mode_buf_o
    );

    modport slave (
        input  en_i, central_i, radius_i, mode_i,
        output busy_o, covered_o, pt_valid_o, last_o, mode_buf_o
    );

endinterface

// File: rtl/cover_scan_dist_cmp.sv
// Two-stage point-in-circle test: stage 1 squares the axis distances,
// stage 2 compares their sum against r^2 and holds the result between points.
module dist_cmp
    import cover_scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               s1_en_i,
    input  logic               s2_en_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] cx_i,
    input  logic [COORD_W-1:0] cy_i,
    input  logic [COORD_W-1:0] r_i,
    output logic               covered_o
);

    logic signed [COORD_W:0]   dx, dy;
    logic [COORD_W-1:0]        abs_x, abs_y;
    logic [2*COORD_W-1:0]      ext_x, ext_y, ext_r;
    logic [2*COORD_W-1:0]      sqx_d, sqx_q, sqy_d, sqy_q;
    logic [2*COORD_W:0]        dist2, r2;
    logic                      cov_d, cov_q;

    always_comb begin
        dx    = $signed({1'b0, x_i}) - $signed({1'b0, cx_i});
        dy    = $signed({1'b0, y_i}) - $signed({1'b0, cy_i});
        // Magnitude of a 5-bit difference in -14..+8 always fits in 4 bits.
        abs_x = dx[COORD_W] ? COORD_W'(-dx) : dx[COORD_W-1:0];
        abs_y = dy[COORD_W] ? COORD_W'(-dy) : dy[COORD_W-1:0];
        ext_x = {{COORD_W{1'b0}}, abs_x};
        ext_y = {{COORD_W{1'b0}}, abs_y};
        ext_r = {{COORD_W{1'b0}}, r_i};
        sqx_d = s1_en_i ? ext_x * ext_x : sqx_q;
        sqy_d = s1_en_i ? ext_y * ext_y : sqy_q;
        dist2 = {1'b0, sqx_q} + {1'b0, sqy_q};
        r2    = {1'b0, ext_r * ext_r};
        cov_d = s2_en_i ? (dist2 <= r2) : cov_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sqx_q <= '0;
            sqy_q <= '0;
            cov_q <= 1'b0;
        end else begin
            sqx_q <= sqx_d;
            sqy_q <= sqy_d;
            cov_q <= cov_d;
        end
    end

    assign covered_o = cov_q;

endmodule

// File: rtl/cover_scan.sv
// Walks the 8x8 grid once per start pulse and streams a 3-bit circle-coverage
// vector per point, with latched centres, radii and mode held for the scan.
//
//   state    | meaning
//   ST_IDLE  | waiting for en_i; outputs idle, busy drops one edge after entry
//   ST_SCAN  | issuing one grid point per cycle, x inner, y outer
//   ST_DRAIN | last point issued; waiting for it to leave the pipeline
module cover_scan
    import cover_scan_pkg::*;
(
    input logic         clk,
    input logic         rst,
    cover_scan_if.slave bus
);

    state_t                state_q, state_d;
    logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
    logic [CENTRAL_W-1:0]  central_q, central_d;
    logic [RADIUS_W-1:0]   radius_q, radius_d;
    logic [MODE_SZ-1:0]    mode_q, mode_d;
    logic                  busy_q, busy_d;
    logic                  s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic                  vld_q, vld_d, last_q, last_d;
    logic                  issue, at_end;
    logic [COVERED_SZ-1:0] cov;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        central_d = central_q;
        radius_d  = radius_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        issue     = (state_q == ST_SCAN);
        at_end    = (x_q == COORD_W'(GRID_MAX)) && (y_q == COORD_W'(GRID_MAX));

        case (state_q)
            ST_IDLE: begin
                busy_d = bus.en_i;
                if (bus.en_i) begin
                    state_d   = ST_SCAN;
                    central_d = bus.central_i;
                    radius_d  = bus.radius_i;
                    mode_d    = bus.mode_i;
                    x_d       = COORD_W'(GRID_MIN);
                    y_d       = COORD_W'(GRID_MIN);
                end
            end
            ST_SCAN: begin
                busy_d = 1'b1;
                if (x_q == COORD_W'(GRID_MAX)) begin
                    x_d = COORD_W'(GRID_MIN);
                    y_d = y_q + COORD_W'(1);
                end else begin
                    x_d = x_q + COORD_W'(1);
                end
                if (at_end) begin
                    state_d = ST_DRAIN;
                    y_d     = COORD_W'(GRID_MIN);
                end
            end
            ST_DRAIN: begin
                busy_d = 1'b1;
                // Stage 1 holds the last point, so the next edge presents last_o.
                if (s1_last_q) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        s1_vld_d  = issue;
        s1_last_d = issue && at_end;
        vld_d     = s1_vld_q;
        last_d    = s1_last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_q       <= COORD_W'(GRID_MIN);
            y_q       <= COORD_W'(GRID_MIN);
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= '0;
            busy_q    <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            central_q <= central_d;
            radius_q  <= radius_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
        end
    end

    for (genvar i = 0; i < NUM_CIRCLES; i++) begin : g_circ
        dist_cmp u_cmp (
            .clk       (clk),
            .rst       (rst),
            .s1_en_i   (issue),
            .s2_en_i   (s1_vld_q),
            .x_i       (x_q),
            .y_i       (y_q),
            .cx_i      (centre_x(central_q, i)),
            .cy_i      (centre_y(central_q, i)),
            .r_i       (radius_of(radius_q, i)),
            .covered_o (cov[COVERED_SZ-1-i])
        );
    end

    assign bus.busy_o     = busy_q;
    assign bus.covered_o  = cov;
    assign bus.pt_valid_o = vld_q;
    assign bus.last_o     = last_q;
    assign bus.mode_buf_o = mode_q;

endmodule

// File: tb/tb_cover_scan.sv
// Scoreboard bench for cover_scan: stimulus queues expected {covered,last} per
// point, an independent monitor pops and compares on every pt_valid_o.
module tb_cover_scan;
    import cover_scan_pkg::*;

    logic clk = 1'b0;
    logic rst;
    cover_scan_if bus ();

    cover_scan dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0]         exp_q[$];
    logic [3:0]         mon_e;
    logic [MODE_SZ-1:0] exp_mode;
    int n_valid = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    logic [2:0] got[64];
    int cxs[3], cys[3], rs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.pt_valid_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: point %0d had no expected entry", n_valid);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("covered[k=%0d]", n_valid), 32'(bus.covered_o), 32'(mon_e[3:1]));
                chk($sformatf("last[k=%0d]", n_valid), 32'(bus.last_o), 32'(mon_e[0]));
            end
            chk("mode_buf", 32'(bus.mode_buf_o), 32'(exp_mode));
            if (n_valid == 0) first_cyc = cyc;
            if (bus.last_o) last_cyc = cyc;
            if (n_valid < 64) got[n_valid] = bus.covered_o;
            n_valid++;
        end
    end

    function automatic logic [2:0] model_cov(input int x, input int y);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 3; i++)
            if ((x - cxs[i]) * (x - cxs[i]) + (y - cys[i]) * (y - cys[i]) <= rs[i] * rs[i])
                c[2-i] = 1'b1;
        return c;
    endfunction

    task automatic set_cfg(input int ax, ay, ar, bx, by, br, cx, cy, cr);
        cxs[0] = ax; cys[0] = ay; rs[0] = ar;
        cxs[1] = bx; cys[1] = by; rs[1] = br;
        cxs[2] = cx; cys[2] = cy; rs[2] = cr;
    endtask

    // kind 0: circle model, 1: only k=27 covered by A, 2: everything covered
    task automatic fill_expected(input int kind);
        logic [2:0] c;
        for (int k = 0; k < 64; k++) begin
            case (kind)
                1:       c = (k == 27) ? 3'b100 : 3'b000;
                2:       c = 3'b111;
                default: c = model_cov(k % 8 + 1, k / 8 + 1);
            endcase
            exp_q.push_back({c, (k == 63)});
        end
    endtask

    task automatic start_scan(input int kind, input logic [MODE_SZ-1:0] mode, output int e_cyc);
        @(negedge clk);
        fill_expected(kind);
        bus.central_i = {4'(cxs[0]), 4'(cys[0]), 4'(cxs[1]), 4'(cys[1]), 4'(cxs[2]), 4'(cys[2])};
        bus.radius_i  = {4'(rs[0]), 4'(rs[1]), 4'(rs[2])};
        bus.mode_i    = mode;
        exp_mode      = mode;
        n_valid       = 0;
        first_cyc     = -1;
        last_cyc      = -1;
        bus.en_i      = 1'b1;
        @(posedge clk);
        #1;
        e_cyc    = cyc;
        bus.en_i = 1'b0;
        chk("busy_after_start", 32'(bus.busy_o), 32'd1);
    endtask

    task automatic wait_done(input int e_cyc);
        int t;
        int low_cyc;
        t = 0;
        low_cyc = -1;
        while (t < 300) begin
            @(negedge clk);
            t++;
            if (!bus.busy_o) begin
                low_cyc = cyc;
                break;
            end
        end
        if (low_cyc < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scan_timeout: busy_o still high after %0d cycles", t);
        end
        chk("first_valid_latency", 32'(first_cyc - e_cyc), 32'd2);
        chk("last_latency", 32'(last_cyc - e_cyc), 32'd65);
        chk("busy_low_latency", 32'(low_cyc - e_cyc), 32'd66);
        chk("valid_count", 32'(n_valid), 32'd64);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int e;
        int t;
        rst           = 1'b1;
        bus.en_i      = 1'b0;
        bus.central_i = '0;
        bus.radius_i  = '0;
        bus.mode_i    = '0;
        exp_mode      = '0;
        #1;
        chk("reset_busy", 32'(bus.busy_o), 32'd0);
        chk("reset_valid", 32'(bus.pt_valid_o), 32'd0);
        chk("reset_last", 32'(bus.last_o), 32'd0);
        chk("reset_covered", 32'(bus.covered_o), 32'd0);
        chk("reset_mode_buf", 32'(bus.mode_buf_o), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Radius 0 at (4,4) covers only k=27; B and C sit off-grid.
        set_cfg(4, 4, 0, 0, 0, 0, 0, 0, 0);
        start_scan(1, MODE2, e);
        wait_done(e);

        // Radius 15 covers the whole grid from any on-grid centre.
        set_cfg(1, 8, 15, 8, 1, 15, 5, 5, 15);
        start_scan(2, MODE3, e);
        wait_done(e);

        // Inclusive boundary for A=(1,1) r=3, plus off-grid centres.
        set_cfg(1, 1, 3, 9, 9, 0, 0, 5, 2);
        start_scan(0, MODE4, e);
        wait_done(e);
        chk("bdy_(4,1)_in", 32'(got[3][2]), 32'd1);
        chk("bdy_(4,2)_out", 32'(got[11][2]), 32'd0);
        chk("bdy_(3,3)_in", 32'(got[18][2]), 32'd1);

        // en_i and input changes during a scan are ignored.
        set_cfg(3, 6, 4, 7, 2, 2, 15, 15, 9);
        start_scan(0, MODE3, e);
        repeat (9) @(negedge clk);
        bus.en_i = 1'b1;
        @(negedge clk);
        bus.en_i = 1'b0;
        repeat (9) @(negedge clk);
        bus.mode_i    = ~bus.mode_i;
        bus.central_i = ~bus.central_i;
        bus.radius_i  = '0;
        wait_done(e);
        repeat (5) @(negedge clk);
        chk("no_second_scan_busy", 32'(bus.busy_o), 32'd0);
        chk("no_second_scan_valids", 32'(n_valid), 32'd64);
        chk("mode_buf_after_ignore", 32'(bus.mode_buf_o), 32'(MODE3));

        // Reset after 30 valids aborts, then a fresh full scan runs.
        set_cfg(2, 2, 5, 6, 7, 3, 8, 1, 1);
        start_scan(0, MODE2, e);
        t = 0;
        while (n_valid < 30 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("reached_30_valids", 32'(n_valid), 32'd30);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        chk("abort_valid", 32'(bus.pt_valid_o), 32'd0);
        chk("abort_last", 32'(bus.last_o), 32'd0);
        chk("abort_covered", 32'(bus.covered_o), 32'd0);
        chk("abort_mode_buf", 32'(bus.mode_buf_o), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        t = n_valid;
        repeat (4) @(negedge clk);
        chk("post_abort_idle", 32'(bus.busy_o), 32'd0);
        chk("post_abort_no_valids", 32'(n_valid), 32'(t));
        set_cfg(5, 3, 2, 1, 8, 4, 8, 8, 0);
        start_scan(0, MODE1, e);
        wait_done(e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cover_scan.md
Name: cover_scan

Overview:
- Sits directly upstream of the LU stage in the SET datapath.
- On a start pulse, latches the three circle centres and radii, then walks the 8x8 grid (x,y in 1..8, x inner, y outer).
- Emits one 3-bit covered vector per grid point, with a valid strobe, for LU to consume.
- Also forwards the latched mode so LU's mode input stays stable for the whole scan.

Parameters:
- COORD_W, 4: width of one x or y coordinate and of one radius.
- GRID_MIN, 1: first grid coordinate on each axis.
- GRID_MAX, 8: last grid coordinate on each axis.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- en_i  in  1  start pulse; sampled only in IDLE
- central_i  in  24  {Ax,Ay,Bx,By,Cx,Cy}, 4 bits each, Ax in [23:20]
- radius_i  in  12  {rA,rB,rC}, rA in [11:8]
- mode_i  in  MODE_SZ  set-operation mode; latched at start
- busy_o  out  1  scan in progress
- covered_o  out  COVERED_SZ  {inA,inB,inC}; bit2 = A, bit0 = C
- pt_valid_o  out  1  covered_o is valid this cycle
- last_o  out  1  marks the 64th point; coincident with pt_valid_o
- mode_buf_o  out  MODE_SZ  latched mode, stable while busy_o is high

Behaviour:
- Reset (async, rst=1): FSM=IDLE. busy_o, pt_valid_o, last_o, covered_o and mode_buf_o all 0. Point counters reset to (GRID_MIN,GRID_MIN). Pipeline valids cleared.
- FSM states:
  - IDLE -> SCAN when en_i=1 at a clock edge. The same edge latches central_i, radius_i and mode_i, and sets busy_o=1.
  - SCAN issues one point per cycle. After issuing (8,8) -> DRAIN.
  - DRAIN waits for the pipeline to empty. On the edge that presents last_o=1 -> IDLE. busy_o clears on the following edge.
- en_i in SCAN or DRAIN is ignored and not queued.
- Point order:
  - Point index k = (y-1)*8 + (x-1), for k = 0..63.
  - x increments 1..8; at x=8 it wraps to 1 and y increments.
- Coverage per circle i, using inclusive compare: (x-xi)^2 + (y-yi)^2 <= ri^2.
  - Differences are signed, 5 bits; range -14..+8.
  - Squares are unsigned, up to 196.
  - Sum is 9 bits, up to 392.
  - ri^2 is zero-extended to 9 bits.
  - No saturation or overflow is possible at these widths.
- Pipeline, 2 stages:
  - Stage 1 registers the squared differences.
  - Stage 2 registers the compare result into covered_o.
  - A point issued in the cycle after start edge E+j appears with pt_valid_o=1 after edge E+j+2.
  - Net result: first valid after edge E+2, last (last_o) after edge E+65, busy_o low after edge E+66.
- pt_valid_o is high for exactly 64 consecutive cycles per scan.
- covered_o holds its last value when pt_valid_o=0.
- Latched inputs:
  - Changing central_i, radius_i or mode_i during a scan has no effect.
  - mode_buf_o changes only at a start edge.
- Reset mid-scan aborts immediately. No further pt_valid_o is produced; the next en_i starts a full fresh scan.
- Radius 0 covers only the centre point, and only if that point is on the grid.
- Centres off-grid (coordinate 0 or 9..15) are legal.

Decomposition:
- Shared def package holds:
  - COVERED_SZ=3 and MODE_SZ=2.
  - The MODE1..MODE4 codes.
  - GRID_MIN/GRID_MAX.
  - The field positions of central_i and radius_i.
- One sub-module, dist_cmp, instantiated 3x:
  - Inputs: point x,y; centre; radius; stage enable.
  - Output: one registered covered bit.
  - Contains both pipeline stages, so the top level holds only the FSM, the counters and the latches.

Test Plan:
- A=(4,4) r=0, B=(0,0) r=0, C=(0,0) r=0 -> covered_o=3'b100 only at k=27; 3'b000 at the other 63 points.
- All radii 15, any centres on the grid -> all 64 outputs are 3'b111; last_o is set only on the 64th pt_valid_o.
- Timing: en_i at edge E -> busy_o=1 after E; first pt_valid_o after E+2; last_o after E+65; busy_o=0 after E+66.
- Boundary: A=(1,1) r=3 -> point (4,1) has bit2=1 (dist^2=9); point (4,2) has bit2=0 (dist^2=10); point (3,3) has bit2=1 (dist^2=8).
- Ignored inputs during a scan: en_i pulse at E+10 and mode_i toggled at E+20 -> still exactly 64 valids, mode_buf_o unchanged, no second scan starts.
- Reset mid-scan: assert rst after 30 valids -> all outputs 0 immediately; a new en_i produces a full 64-point scan starting at k=0.
